// File: rtl/up_tpl_pn_err_counters_pkg.sv
// Shared register map constants and address-decode helpers for the
// per-channel PN error counter bank.
package up_tpl_pn_pkg;

    localparam int MAX_CHANNELS = 64;

    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_STATUS     = 8'h01;
    localparam logic [7:0] OFF_IRQ_MASK   = 8'h02;
    localparam logic [7:0] OFF_CONFIG     = 8'h03;
    localparam logic [7:0] COUNT_BASE     = 8'h10;
    localparam logic [7:0] CH_STATUS_BASE = 8'h50;
    localparam logic [7:0] CH_STATUS_END  = 8'h90;

    localparam int CTRL_CLEAR_ALL_BIT = 0;
    localparam int CTRL_HOLD_BIT      = 1;
    localparam int MASK_SAT_BIT       = 0;
    localparam int MASK_OOS_BIT       = 1;

    typedef enum logic [1:0] {
        REGION_COMMON,
        REGION_COUNT,
        REGION_CH_STATUS,
        REGION_NONE
    } region_e;

    function automatic region_e region_of(input logic [7:0] off);
        if (off < COUNT_BASE)          return REGION_COMMON;
        else if (off < CH_STATUS_BASE) return REGION_COUNT;
        else if (off < CH_STATUS_END)  return REGION_CH_STATUS;
        else                           return REGION_NONE;
    endfunction

    // Channel index within whichever per-channel window the offset falls in.
    function automatic logic [5:0] ch_index(input logic [7:0] off);
        if (off >= CH_STATUS_BASE) return 6'(off - CH_STATUS_BASE);
        else                       return 6'(off - COUNT_BASE);
    endfunction

endpackage

// File: rtl/up_tpl_pn_err_counters_if.sv
// up_* register bus bundle: request side from the master, ack/data back.
interface up_tpl_pn_err_counters_if;

    logic        up_wreq;
    logic [13:0] up_waddr;
    logic [31:0] up_wdata;
    logic        up_wack;
    logic        up_rreq;
    logic [13:0] up_raddr;
    logic [31:0] up_rdata;
    logic        up_rack;

    modport master (
        output up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        input  up_wack, up_rdata, up_rack
    );

    modport slave (
        input  up_wreq, up_waddr, up_wdata, up_rreq, up_raddr,
        output up_wack, up_rdata, up_rack
    );

endinterface

// File: rtl/up_tpl_pn_err_counters_sat_counter.sv
// Saturating event counter with freeze and a clear that overrides any
// coincident increment.
module up_tpl_sat_counter #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    input  logic                     clr,
    input  logic                     hold,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     saturated
);

    localparam logic [COUNTER_WIDTH-1:0] MAX_COUNT = '1;

    logic [COUNTER_WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !hold && (count_q != MAX_COUNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign saturated = (count_q == MAX_COUNT);

endmodule

// File: rtl/up_tpl_pn_err_counters.sv
// Per-channel PN error counter bank on the up_* bus: saturating counts,
// sticky OOS flags, hold/clear control and a maskable interrupt.
module up_tpl_pn_err_counters
    import up_tpl_pn_pkg::*;
#(
    parameter int         NUM_CHANNELS  = 1,
    parameter int         COUNTER_WIDTH = 16,
    parameter logic [5:0] COMMON_ID     = 6'h3
) (
    input  logic                    up_clk,
    input  logic                    up_rst,
    input  logic [NUM_CHANNELS-1:0] pn_err,
    input  logic [NUM_CHANNELS-1:0] pn_oos,
    up_tpl_pn_err_counters_if.slave up_bus,
    output logic                    up_irq
);

    logic [COUNTER_WIDTH-1:0] count [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  sat, cnt_clr, sticky_w1c, sticky_d, sticky_q;
    logic                     hold_d, hold_q;
    logic [1:0]               mask_d, mask_q;
    logic                     wack_d, wack_q, rack_d, rack_q, irq_d, irq_q;
    logic [31:0]              rdata_d, rdata_q;
    logic                     wr_hit, rd_hit, clear_all;
    logic [7:0]               woff, roff;
    logic [5:0]               wr_idx, rd_idx;
    region_e                  wr_region, rd_region;
    logic                     wdata_unused;

    assign wdata_unused = ^up_bus.up_wdata[31:2];

    assign woff      = up_bus.up_waddr[7:0];
    assign roff      = up_bus.up_raddr[7:0];
    assign wr_hit    = up_bus.up_wreq && (up_bus.up_waddr[13:8] == COMMON_ID);
    assign rd_hit    = up_bus.up_rreq && (up_bus.up_raddr[13:8] == COMMON_ID);
    assign wr_region = region_of(woff);
    assign rd_region = region_of(roff);
    assign wr_idx    = ch_index(woff);
    assign rd_idx    = ch_index(roff);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        up_tpl_sat_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_cnt (
            .clk       (up_clk),
            .rst       (up_rst),
            .inc       (pn_err[g] & ~pn_oos[g]),
            .clr       (cnt_clr[g]),
            .hold      (hold_q),
            .count     (count[g]),
            .saturated (sat[g])
        );
    end

    // Writes act on the edge that raises up_wack, so clears beat same-cycle events.
    always_comb begin
        hold_d     = hold_q;
        mask_d     = mask_q;
        clear_all  = 1'b0;
        cnt_clr    = '0;
        sticky_w1c = '0;
        if (wr_hit && (woff == OFF_CTRL)) begin
            hold_d    = up_bus.up_wdata[CTRL_HOLD_BIT];
            clear_all = up_bus.up_wdata[CTRL_CLEAR_ALL_BIT];
        end
        if (wr_hit && (woff == OFF_IRQ_MASK)) begin
            mask_d = up_bus.up_wdata[1:0];
        end
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (wr_hit && (wr_region == REGION_COUNT) && (wr_idx == 6'(i))) begin
                cnt_clr[i] = 1'b1;
            end
            if (wr_hit && (wr_region == REGION_CH_STATUS) && (wr_idx == 6'(i))) begin
                sticky_w1c[i] = up_bus.up_wdata[0];
            end
        end
        cnt_clr  = cnt_clr | {NUM_CHANNELS{clear_all}};
        // A live OOS in the clear cycle re-sets the flag.
        sticky_d = (sticky_q & ~sticky_w1c & ~{NUM_CHANNELS{clear_all}}) | pn_oos;
        wack_d   = wr_hit;
        irq_d    = (mask_q[MASK_SAT_BIT] & (|sat)) | (mask_q[MASK_OOS_BIT] & (|sticky_q));
    end

    always_comb begin
        rdata_d = '0;
        rack_d  = rd_hit;
        if (rd_hit) begin
            case (rd_region)
                REGION_COMMON: begin
                    case (roff)
                        OFF_CTRL:     rdata_d = {30'd0, hold_q, 1'b0};
                        OFF_STATUS:   rdata_d = {29'd0, irq_q, |sticky_q, |sat};
                        OFF_IRQ_MASK: rdata_d = {30'd0, mask_q};
                        OFF_CONFIG:   rdata_d = {16'd0, 8'(COUNTER_WIDTH), 8'(NUM_CHANNELS)};
                        default:      rdata_d = '0;
                    endcase
                end
                REGION_COUNT: begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (rd_idx == 6'(i)) rdata_d = 32'(count[i]);
                    end
                end
                REGION_CH_STATUS: begin
                    for (int i = 0; i < NUM_CHANNELS; i++) begin
                        if (rd_idx == 6'(i)) rdata_d = {29'd0, pn_oos[i], sat[i], sticky_q[i]};
                    end
                end
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            sticky_q <= '0;
            hold_q   <= 1'b0;
            mask_q   <= '0;
            wack_q   <= 1'b0;
            rack_q   <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            hold_q   <= hold_d;
            mask_q   <= mask_d;
            wack_q   <= wack_d;
            rack_q   <= rack_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign up_bus.up_wack  = wack_q;
    assign up_bus.up_rack  = rack_q;
    assign up_bus.up_rdata = rdata_q;
    assign up_irq          = irq_q;

endmodule

// File: tb/tb_up_tpl_pn_err_counters.sv
// Directed bench for the PN error counter bank (4 channels, 8-bit counters).
module tb_up_tpl_pn_err_counters;

    localparam int NCH = 4;

    logic           up_clk = 1'b0;
    logic           up_rst;
    logic [NCH-1:0] pn_err;
    logic [NCH-1:0] pn_oos;
    logic           up_irq;
    int             total = 0;
    int             bad   = 0;

    up_tpl_pn_err_counters_if bus_if ();

    up_tpl_pn_err_counters #(
        .NUM_CHANNELS  (NCH),
        .COUNTER_WIDTH (8),
        .COMMON_ID     (6'h3)
    ) dut (
        .up_clk (up_clk),
        .up_rst (up_rst),
        .pn_err (pn_err),
        .pn_oos (pn_oos),
        .up_bus (bus_if.slave),
        .up_irq (up_irq)
    );

    always #5 up_clk = ~up_clk;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] rdata;
        logic        rack;
    } rd_vec_t;

    rd_vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_read(input logic [13:0] addr, output logic [31:0] data, output logic ack);
        @(posedge up_clk); #1;
        bus_if.up_rreq  = 1'b1;
        bus_if.up_raddr = addr;
        @(posedge up_clk); #1;
        bus_if.up_rreq  = 1'b0;
        data = bus_if.up_rdata;
        ack  = bus_if.up_rack;
    endtask

    task automatic expect_read(input string name, input logic [13:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        a;
        bus_read(addr, d, a);
        check({name, " rack"}, 32'(a), 32'd1);
        check(name, d, exp);
    endtask

    task automatic bus_write(input logic [13:0] addr, input logic [31:0] data, input logic exp_ack);
        @(posedge up_clk); #1;
        bus_if.up_wreq  = 1'b1;
        bus_if.up_waddr = addr;
        bus_if.up_wdata = data;
        @(posedge up_clk); #1;
        bus_if.up_wreq  = 1'b0;
        check($sformatf("wack @%h", addr), 32'(bus_if.up_wack), 32'(exp_ack));
    endtask

    task automatic pulse(input int ch, input int n, input logic err, input logic oos);
        @(posedge up_clk); #1;
        pn_err[ch] = err;
        pn_oos[ch] = oos;
        repeat (n) @(posedge up_clk);
        #1;
        pn_err[ch] = 1'b0;
        pn_oos[ch] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        a;

        vecs[0]  = '{14'h0303, 32'h0000_0804, 1'b1};
        vecs[1]  = '{14'h0300, 32'h0, 1'b1};
        vecs[2]  = '{14'h0301, 32'h0, 1'b1};
        vecs[3]  = '{14'h0302, 32'h0, 1'b1};
        vecs[4]  = '{14'h0310, 32'h0, 1'b1};
        vecs[5]  = '{14'h0311, 32'h0, 1'b1};
        vecs[6]  = '{14'h0312, 32'h0, 1'b1};
        vecs[7]  = '{14'h0313, 32'h0, 1'b1};
        vecs[8]  = '{14'h0350, 32'h0, 1'b1};
        vecs[9]  = '{14'h0351, 32'h0, 1'b1};
        vecs[10] = '{14'h0352, 32'h0, 1'b1};
        vecs[11] = '{14'h0353, 32'h0, 1'b1};
        vecs[12] = '{14'h0304, 32'h0, 1'b1};
        vecs[13] = '{14'h0314, 32'h0, 1'b1};
        vecs[14] = '{14'h0403, 32'h0, 1'b0};
        vecs[15] = '{14'h0210, 32'h0, 1'b0};

        up_rst          = 1'b1;
        pn_err          = '0;
        pn_oos          = '0;
        bus_if.up_wreq  = 1'b0;
        bus_if.up_waddr = '0;
        bus_if.up_wdata = '0;
        bus_if.up_rreq  = 1'b0;
        bus_if.up_raddr = '0;
        repeat (3) @(posedge up_clk);
        #1;
        up_rst = 1'b0;
        check("reset irq", 32'(up_irq), 32'd0);
        check("reset wack", 32'(bus_if.up_wack), 32'd0);
        check("reset rack", 32'(bus_if.up_rack), 32'd0);
        check("reset rdata", bus_if.up_rdata, 32'd0);

        for (int i = 0; i < 16; i++) begin
            bus_read(vecs[i].addr, d, a);
            check($sformatf("vec%0d rack @%h", i, vecs[i].addr), 32'(a), 32'(vecs[i].rack));
            check($sformatf("vec%0d rdata @%h", i, vecs[i].addr), d, vecs[i].rdata);
        end

        // Counting, then OOS gating on channel 2
        pulse(2, 10, 1'b1, 1'b0);
        expect_read("count2", 14'h0312, 32'd10);
        expect_read("count1 idle", 14'h0311, 32'd0);
        @(posedge up_clk); #1;
        pn_err[2] = 1'b1;
        pn_oos[2] = 1'b1;
        repeat (5) @(posedge up_clk);
        #1;
        pn_err[2] = 1'b0;
        expect_read("ch_status2 oos live", 14'h0352, 32'h5);
        expect_read("count2 gated", 14'h0312, 32'd10);
        pn_oos[2] = 1'b0;
        expect_read("ch_status2 sticky", 14'h0352, 32'h1);
        expect_read("status sticky", 14'h0301, 32'h2);
        bus_write(14'h0352, 32'h1, 1'b1);
        expect_read("ch_status2 w1c", 14'h0352, 32'h0);

        // Saturation and interrupt on channel 1
        bus_write(14'h0302, 32'h1, 1'b1);
        @(posedge up_clk); #1;
        pn_err[1] = 1'b1;
        repeat (255) @(posedge up_clk);
        #1;
        check("irq before sat", 32'(up_irq), 32'd0);
        @(posedge up_clk); #1;
        check("irq after sat", 32'(up_irq), 32'd1);
        repeat (44) @(posedge up_clk);
        #1;
        pn_err[1] = 1'b0;
        expect_read("count1 sat", 14'h0311, 32'd255);
        expect_read("status sat", 14'h0301, 32'h5);
        expect_read("ch_status1 sat", 14'h0351, 32'h2);
        bus_write(14'h0311, 32'h0, 1'b1);
        check("irq at clear", 32'(up_irq), 32'd1);
        @(posedge up_clk); #1;
        check("irq after clear", 32'(up_irq), 32'd0);
        expect_read("count1 cleared", 14'h0311, 32'd0);

        // Hold on channel 0, then CLEAR_ALL against a coincident event
        pulse(0, 3, 1'b1, 1'b0);
        expect_read("count0 pre", 14'h0310, 32'd3);
        bus_write(14'h0300, 32'h2, 1'b1);
        expect_read("ctrl hold", 14'h0300, 32'h2);
        for (int k = 0; k < 5; k++) pulse(0, 1, 1'b1, 1'b0);
        bus_write(14'h0300, 32'h0, 1'b1);
        expect_read("count0 held", 14'h0310, 32'd3);
        pulse(3, 1, 1'b0, 1'b1);
        expect_read("count2 pre clear_all", 14'h0312, 32'd10);
        @(posedge up_clk); #1;
        pn_err[0]       = 1'b1;
        bus_if.up_wreq  = 1'b1;
        bus_if.up_waddr = 14'h0300;
        bus_if.up_wdata = 32'h1;
        @(posedge up_clk); #1;
        pn_err[0]      = 1'b0;
        bus_if.up_wreq = 1'b0;
        check("clear_all wack", 32'(bus_if.up_wack), 32'd1);
        expect_read("count0 clear_all", 14'h0310, 32'd0);
        expect_read("count2 clear_all", 14'h0312, 32'd0);
        expect_read("ch_status3 clear_all", 14'h0353, 32'h0);
        expect_read("ctrl self-clear", 14'h0300, 32'h0);

        // Sticky OOS W1C on channel 3, including set-wins
        pulse(3, 1, 1'b0, 1'b1);
        expect_read("ch_status3 set", 14'h0353, 32'h1);
        bus_write(14'h0353, 32'h1, 1'b1);
        expect_read("ch_status3 w1c", 14'h0353, 32'h0);
        @(posedge up_clk); #1;
        pn_oos[3] = 1'b1;
        bus_write(14'h0353, 32'h1, 1'b1);
        expect_read("ch_status3 set wins", 14'h0353, 32'h5);
        pn_oos[3] = 1'b0;
        expect_read("ch_status3 after", 14'h0353, 32'h1);
        expect_read("status oos no irq", 14'h0301, 32'h2);

        // Off-page and unmapped writes, then concurrent read/write
        bus_write(14'h0400, 32'h2, 1'b0);
        bus_write(14'h0304, 32'hFFFF_FFFF, 1'b1);
        expect_read("unmapped after write", 14'h0304, 32'h0);
        pulse(0, 2, 1'b1, 1'b0);
        expect_read("count0 not held", 14'h0310, 32'd2);
        @(posedge up_clk); #1;
        bus_if.up_wreq  = 1'b1;
        bus_if.up_waddr = 14'h0310;
        bus_if.up_rreq  = 1'b1;
        bus_if.up_raddr = 14'h0310;
        @(posedge up_clk); #1;
        bus_if.up_wreq = 1'b0;
        bus_if.up_rreq = 1'b0;
        check("concurrent rdata", bus_if.up_rdata, 32'd2);
        check("concurrent rack", 32'(bus_if.up_rack), 32'd1);
        expect_read("count0 concurrent clear", 14'h0310, 32'd0);
        @(posedge up_clk); #1;
        check("rdata idle", bus_if.up_rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/up_tpl_pn_err_counters.md
Name: up_tpl_pn_err_counters

Overview:
- Per-channel PN error counter bank for the JESD204 TPL ADC.
- Sits on the same up_* register bus as the ADC common, ADC channel and TPL common register blocks, in its own COMMON_ID page.
- Generalises the single aggregated PN error/OOS status bit into per-channel saturating error counts, sticky OOS flags, hold/clear control and a maskable interrupt.
- pn_err/pn_oos arrive already synchronised to up_clk; this block does no clock-domain crossing.

Parameters:
- NUM_CHANNELS, 1, number of monitored channels (1..64).
- COUNTER_WIDTH, 16, error counter width in bits (8..32).
- COMMON_ID, 6'h3, register page; the block decodes addresses {COMMON_ID, 8'hxx}.

Ports:
- up_clk  in  1  register/bus clock; the only clock.
- up_rst  in  1  synchronous, active-high reset.
- pn_err  in  NUM_CHANNELS  per-channel PN mismatch strobe, one event per cycle high.
- pn_oos  in  NUM_CHANNELS  per-channel PN out-of-sync level.
- up_wreq  in  1  write request, single cycle.
- up_waddr  in  14  write word address.
- up_wdata  in  32  write data.
- up_wack  out  1  write acknowledge.
- up_rreq  in  1  read request, single cycle.
- up_raddr  in  14  read word address.
- up_rdata  out  32  read data; zero when not acknowledging.
- up_rack  out  1  read acknowledge.
- up_irq  out  1  interrupt level.

Behaviour:
- Reset (synchronous, up_rst=1): all of the following are 0: counters, sticky flags, CTRL, IRQ_MASK, up_wack, up_rack, up_rdata, up_irq.
- Decode: a request is addressed when addr[13:8]==COMMON_ID.
  - up_wack/up_rack assert exactly 1 cycle after an addressed up_wreq/up_rreq, for 1 cycle.
  - up_rdata is registered and valid in the up_rack cycle; it is 0 otherwise.
  - Unaddressed requests produce no ack.
  - Addressed but unmapped offsets ack with rdata 0; writes to them are ignored.
- Register map (word offsets):
  - 0x00 CTRL: bit0 CLEAR_ALL, self-clearing, reads 0; bit1 HOLD.
  - 0x01 STATUS (RO): bit0 = any channel saturated; bit1 = any sticky OOS; bit2 = up_irq.
  - 0x02 IRQ_MASK: bit0 enables saturation irq; bit1 enables OOS irq.
  - 0x03 CONFIG (RO): [7:0] NUM_CHANNELS; [15:8] COUNTER_WIDTH.
  - 0x10+i COUNT[i]: zero-extended count; any write clears channel i.
  - 0x50+i CH_STATUS[i]: bit0 sticky OOS (W1C); bit1 saturated (RO); bit2 live pn_oos (RO).
  - Channel offsets for i >= NUM_CHANNELS read 0.
- Counting:
  - COUNT[i] increments by 1 in each cycle with pn_err[i]=1, pn_oos[i]=0 and HOLD=0.
  - COUNT[i] saturates at 2^COUNTER_WIDTH-1 and never wraps.
  - saturated[i] = (COUNT[i] == max), combinational from the counter.
- HOLD=1: counters freeze; events during hold are discarded, not buffered.
- Clear precedence: a CLEAR_ALL write or per-channel COUNT write takes effect 1 cycle after up_wreq (the same edge as up_wack). In that cycle clear wins: the counter becomes 0 and any coincident event is dropped. CLEAR_ALL also clears all sticky OOS flags.
- Sticky OOS:
  - Set on any cycle with pn_oos[i]=1.
  - Cleared by writing 1 to bit0 of CH_STATUS[i].
  - If pn_oos[i]=1 in the clear cycle, set wins and the flag stays 1.
- up_irq, registered, 1-cycle latency:
  - up_irq = (MASK[0] & any saturated) | (MASK[1] & any sticky OOS).
- Read snapshot: a read returns the value registered at the edge after up_rreq; counts can change on the same edge. Atomic multi-channel reads use HOLD.
- Simultaneous up_wreq and up_rreq are independent; the read returns the pre-write value.

Decomposition:
- Shared package up_tpl_pn_pkg holds:
  - register offset constants: CTRL, STATUS, IRQ_MASK, CONFIG, COUNT_BASE=0x10, CH_STATUS_BASE=0x50;
  - CTRL and IRQ_MASK bit indices;
  - MAX_CHANNELS=64.
- One sub-module, up_tpl_sat_counter: a COUNTER_WIDTH saturating counter with inc, clr and hold inputs, count and saturated outputs, clear precedence as above. It is instantiated NUM_CHANNELS times in a generate loop.

Test Plan:
- Reset, then read CONFIG with NUM_CHANNELS=4, COUNTER_WIDTH=8 -> rack 1 cycle after rreq, rdata 0x0000_0804; all COUNT and CH_STATUS read 0; up_irq=0.
- Drive pn_err[2] high for 10 cycles with pn_oos=0 -> COUNT[2] (0x12) reads 10; other channels read 0. Repeat with pn_oos[2]=1 -> count unchanged, CH_STATUS[2]=0x5.
- Hold pn_err[1] for 300 cycles (COUNTER_WIDTH=8) -> COUNT[1]=255 with no wrap. With IRQ_MASK=0x1, up_irq rises 1 cycle after saturation and STATUS=0x5. Write COUNT[1] -> reads 0 and up_irq falls.
- Write CTRL=0x2 (HOLD), pulse pn_err[0] 5 times, then write CTRL=0x0 -> COUNT[0] unchanged. Write CTRL=0x1 in a cycle with pn_err[0]=1 -> COUNT[0]=0 and the event is dropped.
- Pulse pn_oos[3] for 1 cycle, then write CH_STATUS[3]=0x1 -> bit0 reads 0. Write the W1C while pn_oos[3]=1 -> bit0 stays 1.
- Issue rreq/wreq to page COMMON_ID+1 -> no rack/wack and rdata stays 0; unmapped offset 0x04 -> ack with rdata 0.
